mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 resetn  input  1  reset, synchronous, active-low.
REQ-003 i_req  input  1  fetch-side read request; held until i_addr_ok.
REQ-004 i_addr  input  32  fetch read address.
REQ-005 i_addr_ok  output  1  fetch request accepted downstream.
REQ-006 i_data_ok  output  1  fetch read data valid, one-cycle pulse.
REQ-007 i_rdata  output  32  fetch read data, valid with i_data_ok.
REQ-008 i_cancel  input  1  discard the outstanding fetch response (exception/ertn redirect).
REQ-009 d_req  input  1  data-side request; held until d_addr_ok.
REQ-010 d_wr  input  1  1 = write, 0 = read.
REQ-011 d_wstrb  input  4  write byte enables.
REQ-012 d_addr  input  32  data address.
REQ-013 d_wdata  input  32  write data.
REQ-014 d_addr_ok  output  1  data request accepted downstream.
REQ-015 d_data_ok  output  1  data read return or write completion, one-cycle pulse.
REQ-016 d_rdata  output  32  data read data, valid with d_data_ok.
REQ-017 m_req  output  1  shared-port request.
REQ-018 m_wr  output  1  shared-port write flag.
REQ-019 m_wstrb  output  4  shared-port byte enables.
REQ-020 m_addr  output  32  shared-port address.
REQ-021 m_wdata  output  32  shared-port write data.
REQ-022 m_addr_ok  input  1  shared-port request accepted.
REQ-023 m_data_ok  input  1  shared-port response valid.
REQ-024 m_rdata  input  32  shared-port read data.

Function
REQ-025 FSM states: IDLE, ADDR and RESP. Only one transaction is outstanding at a time.
REQ-026 IDLE: if i_req or d_req, register the owner (INST/DATA) per REQ-034 and move to ADDR. m_req SHALL be 0 in IDLE.
REQ-027 ADDR: m_req=1, and m_addr/m_wr/m_wstrb/m_wdata SHALL be driven combinationally from the owner. For INST, m_wr=0, m_wstrb=0 and m_wdata=0.
REQ-028 ADDR with m_addr_ok=1: the owner's addr_ok SHALL be 1 in the same cycle and the FSM moves to RESP. Otherwise the FSM stays in ADDR.
REQ-029 RESP with m_data_ok=1: the owner's data_ok SHALL pulse for one cycle, its rdata SHALL equal m_rdata, and the FSM returns to IDLE.
REQ-030 Minimum latency: a request seen in IDLE at cycle N gives m_req=1 at N+1. With m_addr_ok at N+1 and m_data_ok at N+2, data_ok occurs at N+2. The next grant is at N+3.
REQ-031 i_cancel=1 while owner=INST in ADDR or RESP sets a discard flag. The transaction still completes on the port, but i_data_ok SHALL stay 0 for it. i_cancel in the same cycle as m_data_ok also suppresses i_data_ok. The flag clears on entry to IDLE. i_cancel has no effect when owner=DATA or in IDLE.
REQ-032 m_data_ok outside RESP and m_addr_ok outside ADDR SHALL be ignored.
REQ-033 A non-owner's addr_ok and data_ok SHALL be 0. i_rdata and d_rdata SHALL be m_rdata when their own data_ok is 1, and 0 otherwise.
REQ-034 Default arbitration is fixed priority: DATA wins over INST when both request in IDLE.

Reset
REQ-035 On resetn=0 at a clock edge: FSM=IDLE, owner=INST, discard flag=0, last-served=INST. All outputs are 0 in the following cycle. Reset mid-transaction abandons that transaction with no data_ok pulse.

Configuration
REQ-036 With ARB_ROUND_ROBIN_EN defined: when both request in IDLE, the requester not served last wins, and last-served updates at each grant. Without the macro, REQ-034 fixed priority applies and no last-served register exists.

Structure
REQ-037 A shared package mem_arb_pkg holds the FSM state encoding (IDLE/ADDR/RESP) and the owner encoding (INST=0, DATA=1). The grant chooser is a sub-module arb_grant (inputs i_req, d_req, last_served; output grant).

Verification
REQ-038 Single fetch: i_req=1, i_addr=0x1C000000, m_addr_ok at the next cycle, m_data_ok one cycle later with m_rdata=0x02800C0C -> i_addr_ok=1 once, i_data_ok=1 once with i_rdata=0x02800C0C.
REQ-039 Write: d_req=1, d_wr=1, d_wstrb=0xF, d_addr=0x1C0F0000, d_wdata=0xDEADBEEF -> m_wr=1 with the same fields; d_data_ok pulses on m_data_ok.
REQ-040 Contention: i_req and d_req both held for 4 transactions -> fixed mode grants DATA each time. With ARB_ROUND_ROBIN_EN, grants are D, I, D, I.
REQ-041 Cancel: fetch in RESP, i_cancel=1 for one cycle, m_data_ok 2 cycles later -> i_data_ok stays 0 and the FSM returns to IDLE. The next fetch returns data normally.
REQ-042 Reset in RESP with m_data_ok in the same cycle -> no data_ok pulse, FSM=IDLE, m_req=0.
REQ-043 Stall: m_addr_ok held 0 for 5 cycles in ADDR -> m_req and m_addr stay stable, and no addr_ok appears until m_addr_ok=1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/data memory port arbiter: FSM states and transaction owner.
// Also provides the helper used by the grant chooser to pick the opposite requester.
package mem_arb_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned StrbW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } owner_e;

  function automatic owner_e otherOwner(input owner_e o);
    return (o == INST) ? DATA : INST;
  endfunction

endpackage

// File: rtl/arb_grant.sv
// Grant chooser: when both sides request, the side not served last wins; a lone requester always wins.
// Fixed DATA priority is obtained by the parent tying last_served to INST.
module arb_grant
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_e last_served,
  output owner_e grant
);

  always_comb begin
    grant = INST;
    if (i_req && d_req) begin
      grant = otherOwner(last_served);
    end else if (d_req) begin
      grant = DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one shared memory port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for alternating grants under contention; default is DATA-first priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_req,
  input  logic [AddrW-1:0] i_addr,
  output logic             i_addr_ok,
  output logic             i_data_ok,
  output logic [DataW-1:0] i_rdata,
  input  logic             i_cancel,
  input  logic             d_req,
  input  logic             d_wr,
  input  logic [StrbW-1:0] d_wstrb,
  input  logic [AddrW-1:0] d_addr,
  input  logic [DataW-1:0] d_wdata,
  output logic             d_addr_ok,
  output logic             d_data_ok,
  output logic [DataW-1:0] d_rdata,
  output logic             m_req,
  output logic             m_wr,
  output logic [StrbW-1:0] m_wstrb,
  output logic [AddrW-1:0] m_addr,
  output logic [DataW-1:0] m_wdata,
  input  logic             m_addr_ok,
  input  logic             m_data_ok,
  input  logic [DataW-1:0] m_rdata
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   discard_q, discard_d;
  owner_e grant;
  owner_e lastServed;
  logic   anyReq;
  logic   instCancel;

  assign anyReq     = i_req || d_req;
  assign instCancel = i_cancel && (owner_q == INST);

  arb_grant u_grant (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_served(lastServed),
    .grant      (grant)
  );

`ifdef ARB_ROUND_ROBIN_EN
  owner_e lastServed_q, lastServed_d;

  assign lastServed = lastServed_q;

  always_comb begin
    lastServed_d = lastServed_q;
    if (state_q == IDLE && anyReq) begin
      lastServed_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lastServed_q <= INST;
    end else begin
      lastServed_q <= lastServed_d;
    end
  end
`else
  // Pretending INST was always served last makes the chooser favour DATA.
  assign lastServed = INST;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      owner_q   <= INST;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      discard_q <= discard_d;
    end
  end

  // A cancelled fetch still runs to completion on the port; only its response is dropped.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    discard_d = discard_q;
    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          state_d   = ADDR;
          owner_d   = grant;
          discard_d = 1'b0;
        end
      end
      ADDR: begin
        if (instCancel) begin
          discard_d = 1'b1;
        end
        if (m_addr_ok) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (m_data_ok) begin
          state_d   = IDLE;
          discard_d = 1'b0;
        end else if (instCancel) begin
          discard_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshakes are masked while resetn is low so an abandoned transaction never completes.
  always_comb begin
    m_req     = 1'b0;
    m_wr      = 1'b0;
    m_wstrb   = '0;
    m_addr    = '0;
    m_wdata   = '0;
    i_addr_ok = 1'b0;
    d_addr_ok = 1'b0;
    i_data_ok = 1'b0;
    d_data_ok = 1'b0;
    if (state_q == ADDR) begin
      m_req = 1'b1;
      if (owner_q == DATA) begin
        m_wr      = d_wr;
        m_wstrb   = d_wstrb;
        m_addr    = d_addr;
        m_wdata   = d_wdata;
        d_addr_ok = m_addr_ok && resetn;
      end else begin
        m_addr    = i_addr;
        i_addr_ok = m_addr_ok && resetn;
      end
    end
    if (state_q == RESP && m_data_ok && resetn) begin
      if (owner_q == DATA) begin
        d_data_ok = 1'b1;
      end else begin
        i_data_ok = !discard_q && !i_cancel;
      end
    end
  end

  assign i_rdata = i_data_ok ? m_rdata : '0;
  assign d_rdata = d_data_ok ? m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model; honours ARB_ROUND_ROBIN_EN for arbitration expectations.
module tb_mem_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_rdata;
  logic        i_cancel;
  logic        d_req;
  logic        d_wr;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_wr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;

  mem_port_arbiter dut (
    .clk      (clk),
    .resetn   (resetn),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok),
    .i_rdata  (i_rdata),
    .i_cancel (i_cancel),
    .d_req    (d_req),
    .d_wr     (d_wr),
    .d_wstrb  (d_wstrb),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_addr_ok(d_addr_ok),
    .d_data_ok(d_data_ok),
    .d_rdata  (d_rdata),
    .m_req    (m_req),
    .m_wr     (m_wr),
    .m_wstrb  (m_wstrb),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok),
    .m_rdata  (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  // Transaction-level reference: one request in flight, described by who owns it and how far it got.
  bit mActive, mAccepted, mOwnerData, mCancelled, mLastData;
  bit expIAddrOk, expDAddrOk;

  // DUT observations from the most recent cycle, plus pulse counters for directed scenarios.
  logic        lastMReq, lastMWr, lastIAddrOk, lastDAddrOk;
  logic [31:0] lastMAddr, lastIRdata, lastDRdata;
  int cntIAddrOk, cntDAddrOk, cntIDataOk, cntDDataOk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit pickData(input bit iReq, input bit dReq, input bit lastData);
    if (iReq && dReq) begin
`ifdef ARB_ROUND_ROBIN_EN
      return !lastData;
`else
      return 1'b1;
`endif
    end
    return dReq;
  endfunction

  task automatic clearInputs();
    i_req = 0; i_addr = '0; i_cancel = 0;
    d_req = 0; d_wr = 0; d_wstrb = '0; d_addr = '0; d_wdata = '0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
  endtask

  task automatic clearCounts();
    cntIAddrOk = 0; cntDAddrOk = 0; cntIDataOk = 0; cntDDataOk = 0;
  endtask

  // One clock cycle: inputs already driven, check outputs against the model, then advance the model.
  task automatic applyStimulus();
    bit expMReq, inResp, expIDataOk, expDDataOk, expMWr;
    logic [31:0] expMAddr, expMWdata;
    logic [3:0]  expMWstrb;
    #1;
    expMReq    = mActive && !mAccepted;
    inResp     = mActive && mAccepted;
    expIAddrOk = expMReq && !mOwnerData && m_addr_ok && resetn;
    expDAddrOk = expMReq && mOwnerData && m_addr_ok && resetn;
    expIDataOk = inResp && !mOwnerData && m_data_ok && !mCancelled && !i_cancel && resetn;
    expDDataOk = inResp && mOwnerData && m_data_ok && resetn;
    expMAddr   = expMReq ? (mOwnerData ? d_addr : i_addr) : 32'h0;
    expMWr     = expMReq && mOwnerData && d_wr;
    expMWstrb  = (expMReq && mOwnerData) ? d_wstrb : 4'h0;
    expMWdata  = (expMReq && mOwnerData) ? d_wdata : 32'h0;
    checkOutput("m_req",     32'(m_req),     32'(expMReq));
    checkOutput("m_addr",    m_addr,         expMAddr);
    checkOutput("m_wr",      32'(m_wr),      32'(expMWr));
    checkOutput("m_wstrb",   32'(m_wstrb),   32'(expMWstrb));
    checkOutput("m_wdata",   m_wdata,        expMWdata);
    checkOutput("i_addr_ok", 32'(i_addr_ok), 32'(expIAddrOk));
    checkOutput("d_addr_ok", 32'(d_addr_ok), 32'(expDAddrOk));
    checkOutput("i_data_ok", 32'(i_data_ok), 32'(expIDataOk));
    checkOutput("d_data_ok", 32'(d_data_ok), 32'(expDDataOk));
    checkOutput("i_rdata",   i_rdata,        expIDataOk ? m_rdata : 32'h0);
    checkOutput("d_rdata",   d_rdata,        expDDataOk ? m_rdata : 32'h0);
    lastMReq = m_req; lastMWr = m_wr; lastMAddr = m_addr;
    lastIAddrOk = i_addr_ok; lastDAddrOk = d_addr_ok;
    lastIRdata = i_rdata; lastDRdata = d_rdata;
    cntIAddrOk += int'(i_addr_ok); cntDAddrOk += int'(d_addr_ok);
    cntIDataOk += int'(i_data_ok); cntDDataOk += int'(d_data_ok);
    @(posedge clk);
    if (!resetn) begin
      mActive = 0; mAccepted = 0; mCancelled = 0; mOwnerData = 0; mLastData = 0;
    end else if (!mActive) begin
      if (i_req || d_req) begin
        mOwnerData = pickData(i_req, d_req, mLastData);
        mLastData  = mOwnerData;
        mActive    = 1; mAccepted = 0; mCancelled = 0;
      end
    end else if (!mAccepted) begin
      if (!mOwnerData && i_cancel) mCancelled = 1;
      if (m_addr_ok) mAccepted = 1;
    end else begin
      if (m_data_ok) mActive = 0;
      else if (!mOwnerData && i_cancel) mCancelled = 1;
    end
    #1;
  endtask

  task automatic doReset();
    clearInputs();
    resetn = 0;
    applyStimulus();
    resetn = 1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int expGrant[4];
    int gotGrant;
    bit iPend, dPend;
    clearInputs();
    clearCounts();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    mActive = 0; mAccepted = 0; mCancelled = 0; mOwnerData = 0; mLastData = 0;
    resetn = 1;
    applyStimulus();

    $display("[TB] single fetch");
    doReset(); clearCounts();
    i_req = 1; i_addr = 32'h1C00_0000;
    applyStimulus();
    m_addr_ok = 1;
    applyStimulus();
    i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h0280_0C0C;
    applyStimulus();
    checkOutput("fetch_rdata", lastIRdata, 32'h0280_0C0C);
    m_data_ok = 0;
    applyStimulus();
    checkOutput("fetch_addr_ok_cnt", 32'(cntIAddrOk), 32'd1);
    checkOutput("fetch_data_ok_cnt", 32'(cntIDataOk), 32'd1);

    $display("[TB] single write");
    doReset(); clearCounts();
    d_req = 1; d_wr = 1; d_wstrb = 4'hF; d_addr = 32'h1C0F_0000; d_wdata = 32'hDEAD_BEEF;
    applyStimulus();
    m_addr_ok = 1;
    applyStimulus();
    checkOutput("write_m_wr", 32'(lastMWr), 32'd1);
    checkOutput("write_m_addr", lastMAddr, 32'h1C0F_0000);
    d_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h1234_5678;
    applyStimulus();
    checkOutput("write_data_ok_cnt", 32'(cntDDataOk), 32'd1);
    checkOutput("write_i_side_cnt", 32'(cntIAddrOk + cntIDataOk), 32'd0);

    $display("[TB] contention");
`ifdef ARB_ROUND_ROBIN_EN
    expGrant = '{1, 0, 1, 0};
`else
    expGrant = '{1, 1, 1, 1};
`endif
    doReset(); clearCounts();
    i_req = 1; i_addr = 32'h1C00_0100; d_req = 1; d_wr = 0; d_addr = 32'h0000_2000;
    for (int t = 0; t < 4; t++) begin
      m_addr_ok = 0; m_data_ok = 0;
      applyStimulus();
      m_addr_ok = 1;
      applyStimulus();
      gotGrant = lastDAddrOk ? 1 : (lastIAddrOk ? 0 : 2);
      checkOutput($sformatf("contention_grant%0d", t), 32'(gotGrant), 32'(expGrant[t]));
      m_addr_ok = 0; m_data_ok = 1; m_rdata = $urandom;
      applyStimulus();
    end
    clearInputs();
    applyStimulus();

    $display("[TB] cancel");
    doReset(); clearCounts();
    i_req = 1; i_addr = 32'h1C00_0200;
    applyStimulus();
    m_addr_ok = 1;
    applyStimulus();
    i_req = 0; m_addr_ok = 0; i_cancel = 1;
    applyStimulus();
    i_cancel = 0;
    applyStimulus();
    m_data_ok = 1; m_rdata = 32'hAAAA_5555;
    applyStimulus();
    m_data_ok = 0;
    checkOutput("cancel_data_ok_cnt", 32'(cntIDataOk), 32'd0);
    i_req = 1; i_addr = 32'h1C00_0204;
    applyStimulus();
    checkOutput("cancel_next_m_req", 32'(lastMReq), 32'd0);
    m_addr_ok = 1;
    applyStimulus();
    i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h0BAD_F00D;
    applyStimulus();
    checkOutput("cancel_next_rdata", lastIRdata, 32'h0BAD_F00D);
    checkOutput("cancel_next_cnt", 32'(cntIDataOk), 32'd1);

    $display("[TB] reset in response phase");
    doReset(); clearCounts();
    d_req = 1; d_addr = 32'h0000_3000;
    applyStimulus();
    m_addr_ok = 1;
    applyStimulus();
    d_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hFFFF_0000; resetn = 0;
    applyStimulus();
    resetn = 1; m_data_ok = 0;
    applyStimulus();
    checkOutput("rst_data_ok_cnt", 32'(cntDDataOk + cntIDataOk), 32'd0);
    checkOutput("rst_m_req", 32'(lastMReq), 32'd0);

    $display("[TB] address stall");
    doReset(); clearCounts();
    d_req = 1; d_addr = 32'h0000_1230;
    applyStimulus();
    for (int s = 0; s < 5; s++) begin
      applyStimulus();
      checkOutput("stall_m_req", 32'(lastMReq), 32'd1);
      checkOutput("stall_m_addr", lastMAddr, 32'h0000_1230);
    end
    checkOutput("stall_addr_ok_cnt", 32'(cntDAddrOk), 32'd0);
    m_addr_ok = 1;
    applyStimulus();
    d_req = 0; m_addr_ok = 0; m_data_ok = 1;
    applyStimulus();
    checkOutput("stall_done_cnt", 32'(cntDAddrOk + cntDDataOk), 32'd2);

    $display("[TB] random traffic");
    doReset();
    iPend = 0; dPend = 0;
    for (int c = 0; c < 3000; c++) begin
      resetn = ($urandom_range(79) != 0);
      if (!iPend) begin
        i_addr = $urandom;
        iPend = ($urandom_range(2) == 0);
      end
      if (!dPend) begin
        d_wr = 1'($urandom_range(1)); d_wstrb = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
        dPend = ($urandom_range(2) == 0);
      end
      i_req = iPend; d_req = dPend;
      i_cancel  = ($urandom_range(7) == 0);
      m_addr_ok = 1'($urandom_range(1));
      m_data_ok = ($urandom_range(2) == 0);
      m_rdata   = $urandom;
      applyStimulus();
      if (expIAddrOk) iPend = 0;
      if (expDAddrOk) dPend = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
